// File: rtl/shared_pkg.sv
// Shared FIFO sizing and status types used by the sync_fifo RTL and its bench.
package shared_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    // Per-cycle event flags, registered once per request edge.
    typedef struct packed {
        logic wr_ack;
        logic overflow;
        logic underflow;
    } fifo_evt_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'b00,
        CNT_INC  = 2'b01,
        CNT_DEC  = 2'b10
    } cnt_op_t;

    // Accepted write alone grows the occupancy, accepted read alone shrinks it.
    function automatic cnt_op_t count_op(input logic wr_accept, input logic rd_accept);
        cnt_op_t op;
        op = CNT_HOLD;
        if (wr_accept && !rd_accept) op = CNT_INC;
        if (rd_accept && !wr_accept) op = CNT_DEC;
        return op;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: synchronous write port, combinational read port.
module fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; contents are only meaningful behind the pointers,
    // and leaving it out lets the array map onto plain flops or RAM without a reset tree.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and per-cycle status events.
module sync_fifo
    import shared_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AFULL = CW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  wr_accept;
    logic                  rd_accept;
    fifo_evt_t             evt_d;
    fifo_evt_t             evt_q;
    logic [FIFO_WIDTH-1:0] mem_rd_data;

    assign full        = (count == CNT_FULL);
    assign almostfull  = (count == CNT_AFULL);
    assign empty       = (count == '0);
    assign almostempty = (count == CNT_ONE);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_accept       = 1'b0;
        rd_accept       = 1'b0;
        evt_d           = '0;
        wr_accept       = wr_en && !full;
        rd_accept       = rd_en && !empty;
        evt_d.wr_ack    = wr_accept;
        evt_d.overflow  = wr_en && full;
        evt_d.underflow = rd_en && empty;
    end

    fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
            evt_q    <= '0;
        end else begin
            evt_q <= evt_d;
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Read data is taken straight from the array; no bypass of a same-cycle write.
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= mem_rd_data;
            end
            case (count_op(wr_accept, rd_accept))
                CNT_INC: count <= count + 1'b1;
                CNT_DEC: count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign wr_ack    = evt_q.wr_ack;
    assign overflow  = evt_q.overflow;
    assign underflow = evt_q.underflow;

    a_count_range : assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_FULL);
    a_flags_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with hand-computed expectations.
module tb_sync_fifo;
    import shared_pkg::*;

    localparam int W = FIFO_WIDTH_DEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic         rd_en;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;

    int n_vec = 0;
    int n_err = 0;

    sync_fifo #(
        .FIFO_WIDTH (FIFO_WIDTH_DEF),
        .FIFO_DEPTH (FIFO_DEPTH_DEF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_in     (data_in),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply the request for one clock edge, then sample 1 time unit after it.
    task automatic cycle(input logic w, input logic r, input logic [W-1:0] d);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic f, input logic af,
                               input logic e, input logic ae);
        check({tag, ".full"}, 32'(full), 32'(f));
        check({tag, ".almostfull"}, 32'(almostfull), 32'(af));
        check({tag, ".empty"}, 32'(empty), 32'(e));
        check({tag, ".almostempty"}, 32'(almostempty), 32'(ae));
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_flags("por", 1'b0, 1'b0, 1'b1, 1'b0);
        check("por.data_out", 32'(data_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-operation: count 5, wr_ack high, data_out non-zero.
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, W'(16'h0011 + i));
        cycle(1'b1, 1'b1, 16'h0016);
        check("pre_rst.data_out", 32'(data_out), 32'h0011);
        check("pre_rst.wr_ack", 32'(wr_ack), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst.data_out", 32'(data_out), 32'h0);
        check("rst.wr_ack", 32'(wr_ack), 32'h0);
        check("rst.overflow", 32'(overflow), 32'h0);
        check("rst.underflow", 32'(underflow), 32'h0);
        check_flags("rst", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to capacity.
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1, 1'b0, W'(k));
            check($sformatf("fill%0d.wr_ack", k), 32'(wr_ack), 32'h1);
            check($sformatf("fill%0d.almostfull", k), 32'(almostfull), 32'(k == 7));
            check($sformatf("fill%0d.full", k), 32'(full), 32'(k == 8));
        end
        cycle(1'b1, 1'b0, 16'hDEAD);
        check("ovf.overflow", 32'(overflow), 32'h1);
        check("ovf.wr_ack", 32'(wr_ack), 32'h0);
        check("ovf.full", 32'(full), 32'h1);
        cycle(1'b0, 1'b0, '0);
        check("ovf_clr.overflow", 32'(overflow), 32'h0);

        // Drain in order.
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain%0d.almostempty_before", k), 32'(almostempty), 32'(k == 8));
            cycle(1'b0, 1'b1, '0);
            check($sformatf("drain%0d.data_out", k), 32'(data_out), 32'(k));
        end
        check_flags("drained", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, '0);
        check("udf.underflow", 32'(underflow), 32'h1);
        check("udf.data_out", 32'(data_out), 32'h0008);
        cycle(1'b0, 1'b0, '0);
        check("udf_clr.underflow", 32'(underflow), 32'h0);

        // Simultaneous request while full.
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, W'(16'h0021 + k));
        check("sfull.pre_full", 32'(full), 32'h1);
        cycle(1'b1, 1'b1, 16'h00AA);
        check("sfull.data_out", 32'(data_out), 32'h0021);
        check("sfull.overflow", 32'(overflow), 32'h1);
        check("sfull.wr_ack", 32'(wr_ack), 32'h0);
        check_flags("sfull", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("sfull_drain%0d", k), 32'(data_out), 32'(16'h0022 + k));
        end
        check("sfull_drained.empty", 32'(empty), 32'h1);

        // Simultaneous request while empty: write lands, read rejected, no bypass.
        cycle(1'b1, 1'b1, 16'h0055);
        check("sempty.wr_ack", 32'(wr_ack), 32'h1);
        check("sempty.underflow", 32'(underflow), 32'h1);
        check("sempty.data_out", 32'(data_out), 32'h0028);
        check_flags("sempty", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, '0);
        check("sempty_rd.data_out", 32'(data_out), 32'h0055);
        check("sempty_rd.empty", 32'(empty), 32'h1);

        // Sustained concurrent traffic at count 3 across pointer wrap.
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, W'(16'h0100 + k));
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, W'(16'h0103 + k));
            check($sformatf("wrap%0d.data_out", k), 32'(data_out), 32'(16'h0100 + k));
            check($sformatf("wrap%0d.evt", k), {29'b0, wr_ack, overflow, underflow}, 32'b100);
            check_flags($sformatf("wrap%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1, '0);
            check($sformatf("wrap_drain%0d", k), 32'(data_out), 32'(16'h0114 + k));
        end
        check("wrap_drained.empty", 32'(empty), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
